// File: rtl/mem_checker_top.sv
// mem_checker_top: memory-checker peripheral.
//   A 1024 x 64-bit local RAM (8 byte-wide banks, dual-ported) is loaded over a
//   Wishbone slave port. Software programs a target address and mode through a
//   CSR bank and starts a job. The engine runs either a DUMMY timer or a SINGLE
//   64-bit fetch, then records sticky DONE/ERROR/NONZERO events in STAT.
//   irq is IRQ_EN & |STAT.
// Ports:
//   sys_clk, sys_rst   clock, asynchronous active-high reset
//   wb_*               Wishbone slave (adr[15]=0 RAM, adr[15]=1 read-only mirror)
//   csr_a/we/di/do     CSR bank (bank select csr_a[13:10], word index csr_a[9:0])
//   irq                level interrupt
module mem_checker_top #(
  parameter logic [3:0]  csr_addr     = 4'h0,
  parameter int unsigned dummy_cycles = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        irq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DUMMY,
    S_RD_REQ,
    S_RD_WAIT,
    S_FINISH
  } state_t;

  state_t      state, state_nx;
  logic [15:0] cnt;
  logic        cnt_load, cnt_dec;
  logic [1:0]  mode;
  logic        irq_en;
  logic [2:0]  stat, stat_set, stat_clr;
  logic [31:0] addr_lo, addr_hi, data_lo, data_hi;
  logic        rb_en, latch_data;
  logic [63:0] qa, qb;
  logic [7:0]  mem [8][1024];

  // CSR decode
  logic        csr_sel, csr_wr, start;
  logic [9:0]  csr_idx;
  logic [31:0] csr_rdata;
  logic        busy;

  assign csr_sel = (csr_a[13:10] == csr_addr);
  assign csr_idx = csr_a[9:0];
  assign csr_wr  = csr_sel & csr_we;
  assign busy    = (state != S_IDLE);
  assign start   = csr_wr && (csr_idx == 10'd0) && csr_di[0] && !busy;
  assign stat_clr = (csr_wr && (csr_idx == 10'd1)) ? csr_di[2:0] : 3'b000;
  assign irq     = irq_en & (|stat);

  // Wishbone decode
  logic wb_req, ram_req;
  assign wb_req  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign ram_req = wb_req & ~wb_adr_i[15];

  logic unused_adr_bits;
  assign unused_adr_bits = ^{wb_adr_i[31:16], wb_adr_i[1:0]};

  // Next-state / engine control. The mode for a new job comes from the same
  // CTRL write that carries START, since MODE is updated on that edge too.
  always_comb begin
    state_nx   = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    rb_en      = 1'b0;
    latch_data = 1'b0;
    stat_set   = 3'b000;
    case (state)
      S_IDLE: begin
        if (start) begin
          case (csr_di[2:1])
            2'b00: begin
              state_nx = S_DUMMY;
              cnt_load = 1'b1;
            end
            2'b01:   state_nx = S_RD_REQ;
            default: begin
              state_nx    = S_FINISH;
              stat_set[1] = 1'b1;
            end
          endcase
        end
      end
      S_DUMMY: begin
        if (cnt == '0) state_nx = S_FINISH;
        else           cnt_dec  = 1'b1;
      end
      S_RD_REQ: begin
        if ((addr_hi != '0) || (addr_lo >= 32'h2000) || (addr_lo[2:0] != 3'b000)) begin
          state_nx    = S_FINISH;
          stat_set[1] = 1'b1;
        end else begin
          rb_en    = 1'b1;
          state_nx = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        latch_data  = 1'b1;
        stat_set[2] = (qb != '0);
        state_nx    = S_FINISH;
      end
      S_FINISH: begin
        stat_set[0] = 1'b1;
        state_nx    = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    case (csr_idx)
      10'd0:   csr_rdata = {28'd0, irq_en, mode, busy};
      10'd1:   csr_rdata = {29'd0, stat};
      10'd2:   csr_rdata = addr_lo;
      10'd3:   csr_rdata = addr_hi;
      10'd4:   csr_rdata = data_lo;
      10'd5:   csr_rdata = data_hi;
      default: csr_rdata = '0;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      mode    <= '0;
      irq_en  <= 1'b0;
      stat    <= '0;
      addr_lo <= '0;
      addr_hi <= '0;
      data_lo <= '0;
      data_hi <= '0;
      csr_do  <= '0;
    end else begin
      state <= state_nx;
      if (cnt_load)     cnt <= 16'(dummy_cycles);
      else if (cnt_dec) cnt <= cnt - 16'd1;
      if (csr_wr) begin
        case (csr_idx)
          10'd0: begin
            mode   <= csr_di[2:1];
            irq_en <= csr_di[3];
          end
          10'd2:   addr_lo <= csr_di;
          10'd3:   addr_hi <= csr_di;
          default: ;
        endcase
      end
      // set wins over a simultaneous write-1-to-clear
      stat <= (stat & ~stat_clr) | stat_set;
      if (latch_data) begin
        data_lo <= qb[31:0];
        data_hi <= qb[63:32];
      end
      csr_do <= csr_sel ? csr_rdata : '0;
    end
  end

  // RAM: port A (Wishbone, byte-masked writes into one half) and port B (engine).
  always_ff @(posedge sys_clk) begin
    for (int unsigned b = 0; b < 8; b++) begin
      if (ram_req) begin
        if (wb_we_i && wb_sel_i[b[1:0]] && (wb_adr_i[2] == b[2]))
          mem[b[2:0]][wb_adr_i[12:3]] <= wb_dat_i[{b[1:0], 3'b000} +: 8];
        qa[{b[2:0], 3'b000} +: 8] <= mem[b[2:0]][wb_adr_i[12:3]];
      end
      if (rb_en)
        qb[{b[2:0], 3'b000} +: 8] <= mem[b[2:0]][addr_lo[12:3]];
    end
  end

  // Wishbone ack and mirror read path
  logic        rd_mir, half_q;
  logic [31:0] mir_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wb_ack_o <= 1'b0;
      rd_mir   <= 1'b0;
      half_q   <= 1'b0;
      mir_q    <= '0;
    end else begin
      wb_ack_o <= wb_req;
      if (wb_req) begin
        rd_mir <= wb_adr_i[15];
        half_q <= wb_adr_i[2];
        case (wb_adr_i[14:2])
          13'd0:   mir_q <= data_lo;
          13'd1:   mir_q <= data_hi;
          13'd2:   mir_q <= {29'd0, stat};
          default: mir_q <= '0;
        endcase
      end
    end
  end

  // RAM read data stays in the port-A register, so the output is gated by ack
  // to keep it at 0 outside an acknowledged cycle (including reset).
  always_comb begin
    wb_dat_o = '0;
    if (wb_ack_o) begin
      if (rd_mir)      wb_dat_o = mir_q;
      else if (half_q) wb_dat_o = qa[63:32];
      else             wb_dat_o = qa[31:0];
    end
  end

endmodule

// File: tb/tb_mem_checker_top.sv
// Self-checking bench for mem_checker_top: CSR vector table plus directed
// sequences for DUMMY timing, SINGLE fetch, errors, IRQ, reset and Wishbone.
module tb_mem_checker_top;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di, csr_do;
  logic        irq;

  int passed = 0;
  int total  = 0;

  mem_checker_top #(.csr_addr(4'h0), .dummy_cycles(16)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di), .csr_do(csr_do),
    .irq(irq)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [13:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic csr_wr(input logic [13:0] a, input logic [31:0] d);
    @(negedge sys_clk);
    csr_a = a; csr_di = d; csr_we = 1'b1;
    @(posedge sys_clk); #1;
    csr_we = 1'b0;
  endtask

  task automatic csr_rd(input logic [13:0] a, output logic [31:0] d);
    @(negedge sys_clk);
    csr_a = a; csr_we = 1'b0;
    @(posedge sys_clk); #1;
    d = csr_do;
  endtask

  task automatic csr_chk(input string nm, input logic [13:0] a, input logic [31:0] exp);
    logic [31:0] d;
    csr_rd(a, d);
    chk(nm, d, exp);
  endtask

  // One Wishbone transfer; checks the ack arrives within a bound and drops after one cycle.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd);
    logic ok;
    ok = 1'b0;
    rd = '0;
    @(negedge sys_clk);
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(posedge sys_clk); #1;
      if (wb_ack_o) begin
        ok = 1'b1;
        rd = wb_dat_o;
      end
    end
    @(negedge sys_clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    chk($sformatf("wb ack seen adr=%08h", adr), 32'(ok), 32'd1);
    @(posedge sys_clk); #1;
    chk($sformatf("wb ack single-cycle adr=%08h", adr), 32'(wb_ack_o), 32'd0);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] rd;
    wb_xfer(1'b1, adr, dat, sel, rd);
  endtask

  task automatic wb_read_chk(input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    wb_xfer(1'b0, adr, 32'h0, 4'hF, rd);
    chk($sformatf("wb read %08h", adr), rd, exp);
  endtask

  task automatic run_single_chk(input string nm, input logic [31:0] exp_stat);
    csr_wr(14'd0, 32'hB);
    repeat (6) @(posedge sys_clk);
    csr_chk({nm, " STAT"}, 14'd1, exp_stat);
    chk({nm, " irq"}, 32'(irq), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  pat;

    sys_rst = 1'b1;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    csr_a = '0; csr_we = 1'b0; csr_di = '0;

    // reset state
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset irq", 32'(irq), 32'd0);
    chk("reset ack", 32'(wb_ack_o), 32'd0);
    chk("reset wb_dat_o", wb_dat_o, 32'd0);
    chk("reset csr_do", csr_do, 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;

    // CSR vector table: {we, addr, wdata, expected read}
    vecs.push_back('{1'b1, 14'h0002, 32'h0000_0010, 32'h0});
    vecs.push_back('{1'b0, 14'h0002, 32'h0,         32'h0000_0010});
    vecs.push_back('{1'b1, 14'h0003, 32'hA5A5_0001, 32'h0});
    vecs.push_back('{1'b0, 14'h0003, 32'h0,         32'hA5A5_0001});
    vecs.push_back('{1'b1, 14'h0000, 32'h0000_0008, 32'h0});
    vecs.push_back('{1'b0, 14'h0000, 32'h0,         32'h0000_0008});
    vecs.push_back('{1'b1, 14'h0000, 32'hFFFF_FFF6, 32'h0});
    vecs.push_back('{1'b0, 14'h0000, 32'h0,         32'h0000_0006});
    vecs.push_back('{1'b1, 14'h0000, 32'h0000_0008, 32'h0});
    vecs.push_back('{1'b1, 14'h0004, 32'h0000_1234, 32'h0});
    vecs.push_back('{1'b0, 14'h0004, 32'h0,         32'h0});
    vecs.push_back('{1'b1, 14'h0001, 32'h0000_0007, 32'h0});
    vecs.push_back('{1'b0, 14'h0001, 32'h0,         32'h0});
    vecs.push_back('{1'b0, 14'h0007, 32'h0,         32'h0});
    vecs.push_back('{1'b0, 14'h0402, 32'h0,         32'h0});
    vecs.push_back('{1'b1, 14'h0402, 32'h0000_0055, 32'h0});
    vecs.push_back('{1'b0, 14'h0002, 32'h0,         32'h0000_0010});
    vecs.push_back('{1'b1, 14'h0003, 32'h0,         32'h0});
    vecs.push_back('{1'b0, 14'h0003, 32'h0,         32'h0});
    vecs.push_back('{1'b0, 14'h0000, 32'h0,         32'h0000_0008});
    foreach (vecs[i]) begin
      if (vecs[i].we) csr_wr(vecs[i].a, vecs[i].d);
      else begin
        csr_rd(vecs[i].a, d);
        chk($sformatf("csr vec %0d a=%04h", i, vecs[i].a), d, vecs[i].exp);
      end
    end
    chk("irq idle", 32'(irq), 32'd0);

    // DUMMY job timing
    csr_wr(14'd0, 32'h9);
    csr_chk("dummy busy immediate", 14'd0, 32'h9);
    repeat (15) @(posedge sys_clk);
    csr_chk("dummy busy late", 14'd0, 32'h9);
    csr_chk("dummy no done yet", 14'd1, 32'h0);
    csr_chk("dummy ctrl idle", 14'd0, 32'h8);
    csr_chk("dummy STAT", 14'd1, 32'h1);
    chk("dummy irq", 32'(irq), 32'd1);

    // reset mid-job aborts without event
    csr_wr(14'd0, 32'h9);
    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("rst irq", 32'(irq), 32'd0);
    sys_rst = 1'b0;
    csr_chk("rst CTRL", 14'd0, 32'h0);
    csr_chk("rst STAT", 14'd1, 32'h0);
    csr_chk("rst ADDRESS_LOW", 14'd2, 32'h0);
    csr_chk("rst DATA_LOW", 14'd4, 32'h0);
    repeat (25) @(posedge sys_clk);
    csr_chk("rst no late event", 14'd1, 32'h0);

    // Wishbone RAM load and read
    wb_write(32'h1000, 32'hDEAD_BEEF, 4'hF);
    wb_write(32'h1004, 32'h0000_0001, 4'hF);
    wb_read_chk(32'h1000, 32'hDEAD_BEEF);
    wb_read_chk(32'h1004, 32'h0000_0001);

    // held strobe: ack alternates, never two in a row
    @(negedge sys_clk);
    wb_adr_i = 32'h1000; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge sys_clk); #1;
      pat[i] = wb_ack_o;
    end
    @(negedge sys_clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    chk("ack pattern held stb", 32'(pat), 32'h5);

    // SINGLE fetch
    csr_wr(14'd2, 32'h1000);
    run_single_chk("single", 32'h5);
    csr_chk("single DATA_LOW", 14'd4, 32'hDEAD_BEEF);
    csr_chk("single DATA_HIGH", 14'd5, 32'h0000_0001);
    wb_read_chk(32'h8004, 32'h0000_0001);
    wb_read_chk(32'h8000, 32'hDEAD_BEEF);
    wb_read_chk(32'h8008, 32'h0000_0005);
    wb_read_chk(32'h800C, 32'h0);
    wb_write(32'h8000, 32'h0, 4'hF);
    wb_read_chk(32'h8000, 32'hDEAD_BEEF);

    // W1C and restart
    csr_wr(14'd1, 32'h7);
    csr_chk("w1c STAT", 14'd1, 32'h0);
    chk("w1c irq", 32'(irq), 32'd0);
    run_single_chk("restart", 32'h5);
    csr_wr(14'd1, 32'h7);
    csr_chk("restart clear", 14'd1, 32'h0);

    // error paths
    csr_wr(14'd2, 32'h2000);
    run_single_chk("err range", 32'h3);
    csr_chk("err DATA_LOW kept", 14'd4, 32'hDEAD_BEEF);
    csr_chk("err DATA_HIGH kept", 14'd5, 32'h0000_0001);
    csr_wr(14'd0, 32'h2);
    chk("irq_en off", 32'(irq), 32'd0);
    csr_wr(14'd1, 32'h7);
    csr_wr(14'd2, 32'h1004);
    run_single_chk("err align", 32'h3);
    csr_wr(14'd1, 32'h7);
    csr_wr(14'd2, 32'h1000);
    csr_wr(14'd3, 32'h1);
    run_single_chk("err addr_high", 32'h3);
    csr_wr(14'd3, 32'h0);
    csr_wr(14'd1, 32'h7);
    csr_wr(14'd0, 32'hF);
    repeat (4) @(posedge sys_clk);
    csr_chk("err mode11 STAT", 14'd1, 32'h3);
    csr_chk("err mode11 CTRL", 14'd0, 32'hE);
    csr_wr(14'd1, 32'h7);

    // START while busy is ignored
    csr_wr(14'd0, 32'h9);
    repeat (3) @(posedge sys_clk);
    csr_wr(14'd0, 32'h9);
    repeat (14) @(posedge sys_clk);
    csr_chk("busy start first done", 14'd1, 32'h1);
    csr_wr(14'd1, 32'h7);
    repeat (25) @(posedge sys_clk);
    csr_chk("busy start single done", 14'd1, 32'h0);

    // byte-lane write
    wb_write(32'h1000, 32'h1234_5678, 4'b0010);
    wb_read_chk(32'h1000, 32'hDEAD_56EF);
    wb_read_chk(32'h1004, 32'h0000_0001);
    csr_wr(14'd0, 32'h3);
    repeat (6) @(posedge sys_clk);
    csr_chk("byte engine DATA_LOW", 14'd4, 32'hDEAD_56EF);
    csr_chk("byte engine STAT", 14'd1, 32'h5);
    chk("byte irq disabled", 32'(irq), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
